msx_audio_decim: RTL

// - Downstream of the MSX core audio mix: consumes the signed 16-bit mixed audio (PSG + keybeep + cassette + cartridge)

---
 rtl/msx_audio_pkg.sv | 20 ++
 rtl/msx_dc_block.sv | 42 ++++
 rtl/msx_audio_decim.sv | 110 +++++++++++
 3 files changed

// File: rtl/msx_audio_pkg.sv
// Shared types and saturation helper for the MSX audio decimation path.
package msx_audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic {
    OB_EMPTY,
    OB_FULL
  } obuf_state_e;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return SAMPLE_MAX;
    else if (v < -18'sd32768) return SAMPLE_MIN;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/msx_dc_block.sv
// First-order DC blocker: y = x - x1 + y1 - (y1 >>> DC_SHIFT), saturated to 16 bits.
module msx_dc_block
  import msx_audio_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic [15:0] x_in,
  input  logic        x_valid,
  output logic [15:0] y_out,
  output logic        y_valid
);

  sample_t x_prev, y_prev;
  logic signed [17:0] xe, xpe, ye, y_calc;

  // Feedback uses the saturated output, so 18 bits cover the worst-case sum.
  always_comb begin
    xe     = {{2{x_in[15]}}, x_in};
    xpe    = {{2{x_prev[15]}}, x_prev};
    ye     = {{2{y_prev[15]}}, y_prev};
    y_calc = xe - xpe + ye - (ye >>> DC_SHIFT);
  end

  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      x_prev  <= '0;
      y_prev  <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= x_valid;
      if (x_valid) begin
        x_prev <= x_in;
        y_prev <= sat16(y_calc);
      end
    end
  end

  assign y_out = y_prev;

endmodule

// File: rtl/msx_audio_decim.sv
// Boxcar decimator for the MSX audio mix with a single-entry valid/ready output.
// Optional DC blocker is enabled by defining MSX_AUDIO_DCBLOCK_EN.
module msx_audio_decim
  import msx_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 6,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk21m,
  input  logic        reset_n,
  input  logic        ce_3m58_p,
  input  logic [15:0] audio_in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        clr_overrun
);

  localparam int ACC_W = 16 + DECIM_LOG2;

  logic [DECIM_LOG2-1:0] cnt;
  logic [ACC_W-1:0]      acc, sum;
  sample_t               avg_q;
  logic [1:0]            vld_pipe;
  logic                  new_vld;
  logic [15:0]           new_data;

  obuf_state_e state_q, state_d;
  logic        load, ovr_evt;

  assign sum         = acc + {{DECIM_LOG2{audio_in[15]}}, audio_in};
  assign vld_pipe[0] = ce_3m58_p && (cnt == '1);

  // The closing sample is folded into the average and the window restarts on the same edge.
  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      cnt         <= '0;
      acc         <= '0;
      avg_q       <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (ce_3m58_p) begin
        cnt <= cnt + 1'b1;
        if (vld_pipe[0]) begin
          acc   <= '0;
          avg_q <= sum[DECIM_LOG2 +: 16];
        end else begin
          acc <= sum;
        end
      end
    end
  end

`ifdef MSX_AUDIO_DCBLOCK_EN
  msx_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc (
    .clk21m  (clk21m),
    .reset_n (reset_n),
    .x_in    (avg_q),
    .x_valid (vld_pipe[1]),
    .y_out   (new_data),
    .y_valid (new_vld)
  );
`else
  logic unused_dc_shift;
  assign unused_dc_shift = DC_SHIFT[0];
  assign new_data        = avg_q;
  assign new_vld         = vld_pipe[1];
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_evt = 1'b0;
    case (state_q)
      OB_EMPTY: begin
        if (new_vld) begin
          state_d = OB_FULL;
          load    = 1'b1;
        end
      end
      OB_FULL: begin
        if (new_vld) begin
          load    = 1'b1;
          ovr_evt = !out_ready;
        end else if (out_ready) begin
          state_d = OB_EMPTY;
        end
      end
      default: state_d = OB_EMPTY;
    endcase
  end

  always_ff @(posedge clk21m) begin
    if (!reset_n) begin
      state_q  <= OB_EMPTY;
      out_data <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) out_data <= new_data;
      if (ovr_evt)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign out_valid = (state_q == OB_FULL);

endmodule
